// File: rtl/led_blink_sequencer_if.sv
// rtl/led_blink_sequencer_if.sv - event/LED signal bundle between control logic and the blink sequencer
interface led_blink_sequencer_if #(
    parameter int PEND_W = 3
);
    logic              event_pulse;
    logic              clr_overflow;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output event_pulse,
        output clr_overflow,
        input  led,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  event_pulse,
        input  clr_overflow,
        output led,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/led_blink_sequencer.sv
// rtl/led_blink_sequencer.sv - turns single-cycle event pulses into queued, fixed-length LED blinks
module led_blink_sequencer #(
    parameter int ON_CYCLES  = 12500000,
    parameter int OFF_CYCLES = 12500000,
    parameter int PEND_W     = 3,
    parameter int CNT_W      = 26
) (
    input  logic                   clk_in,
    input  logic                   rst,
    led_blink_sequencer_if.slave   io
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              drop;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        led_d   = led_q;
        drop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                led_d = 1'b0;
                if (io.event_pulse) begin
                    state_d = S_ON;
                    timer_d = '0;
                    led_d   = 1'b1;
                end
            end
            S_ON: begin
                led_d = 1'b1;
                if (timer_q == ON_LAST) begin
                    state_d = S_GAP;
                    timer_d = '0;
                    led_d   = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (io.event_pulse) begin
                    if (pend_q == PEND_MAX) drop   = 1'b1;
                    else                    pend_d = pend_q + 1'b1;
                end
            end
            S_GAP: begin
                led_d = 1'b0;
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    // A new event here either offsets the dequeue or starts the next blink directly.
                    if (pend_q != PEND_ZERO) begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                        if (!io.event_pulse) pend_d = pend_q - 1'b1;
                    end else if (io.event_pulse) begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (io.event_pulse) begin
                        if (pend_q == PEND_MAX) drop   = 1'b1;
                        else                    pend_d = pend_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                led_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        // A drop on the same edge as a clear must leave the flag set.
        if (drop)                 ovf_d = 1'b1;
        else if (io.clr_overflow) ovf_d = 1'b0;
        else                      ovf_d = ovf_q;
    end

    assign io.led      = led_q;
    assign io.busy     = busy_q;
    assign io.pending  = pend_q;
    assign io.overflow = ovf_q;
endmodule
